// File: rtl/dip_chain_reader.sv
// Reader for a chain of 74HC165-style PISO registers: drives LOAD_N/SCLK,
// deserialises WIDTH bits per frame and debounces over STABLE_FRAMES frames.
module dip_chain_reader #(
  parameter int WIDTH         = 16,
  parameter int DIV           = 2,
  parameter int STABLE_FRAMES = 2,
  parameter bit MSB_FIRST     = 1'b1,
  parameter bit AUTO          = 1'b1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_START,
  input  logic             i_Data,
  output logic             o_SCLK,
  output logic             o_LOAD_N,
  output logic [WIDTH-1:0] o_DIP,
  output logic             o_VALID,
  output logic             o_CHANGED,
  output logic             o_BUSY
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam int STB_W = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FRAME} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             half, half_next;
  logic [BIT_W-1:0] bit_idx;
  logic [BIT_W-1:0] place;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] prev_frame;
  logic             prev_valid;
  logic [STB_W-1:0] stable_cnt, cnt_next;

  assign tick  = (div_cnt == DIV_W'(DIV - 1));
  assign place = MSB_FIRST ? (BIT_W'(WIDTH - 1) - bit_idx) : bit_idx;

  // half marks the second DIV-clock half of a LOAD period or of a bit period
  always_comb begin
    state_next = state;
    half_next  = half;
    case (state)
      IDLE:  if (AUTO || i_START) state_next = LOAD;
      LOAD:  if (tick) begin
               half_next = ~half;
               if (half) state_next = SHIFT;
             end
      SHIFT: if (tick) begin
               half_next = ~half;
               if (half && bit_idx == BIT_W'(WIDTH - 1)) state_next = FRAME;
             end
      FRAME: state_next = AUTO ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The very first frame after reset has nothing to compare against
  always_comb begin
    cnt_next = STB_W'(1);
    if (prev_valid && shift_reg == prev_frame)
      cnt_next = (stable_cnt == STB_W'(STABLE_FRAMES)) ? stable_cnt
                                                       : stable_cnt + STB_W'(1);
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state      <= IDLE;
      half       <= 1'b0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      prev_frame <= '0;
      prev_valid <= 1'b0;
      stable_cnt <= '0;
      o_DIP      <= '0;
      o_SCLK     <= 1'b0;
      o_LOAD_N   <= 1'b1;
      o_VALID    <= 1'b0;
      o_CHANGED  <= 1'b0;
      o_BUSY     <= 1'b0;
    end else begin
      state     <= state_next;
      half      <= half_next;
      o_SCLK    <= (state_next == SHIFT) && half_next;
      o_LOAD_N  <= (state_next != LOAD);
      o_BUSY    <= (state_next != IDLE);
      o_VALID   <= 1'b0;
      o_CHANGED <= 1'b0;

      if (state_next != state || tick) div_cnt <= '0;
      else                             div_cnt <= div_cnt + DIV_W'(1);

      if (state == LOAD) bit_idx <= '0;

      // Sample before the rising SCLK edge, advance the index on the falling one
      if (state == SHIFT && tick) begin
        if (!half) shift_reg[place] <= i_Data;
        else       bit_idx <= bit_idx + BIT_W'(1);
      end

      if (state == FRAME) begin
        prev_frame <= shift_reg;
        prev_valid <= 1'b1;
        stable_cnt <= cnt_next;
        if (cnt_next == STB_W'(STABLE_FRAMES)) begin
          o_DIP     <= shift_reg;
          o_VALID   <= 1'b1;
          o_CHANGED <= (shift_reg != o_DIP);
        end
      end
    end
  end

endmodule
